// File: rtl/hilo_muldiv.sv
// Multi-cycle HI/LO multiply/divide unit: 2-cycle multiply, 33-cycle radix-2 restoring divide.
// Define HILO_MADD_EN to build MADD/MADDU/MSUB/MSUBU accumulate support.
module hilo_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] hilo_cur,
  output logic        busy,
  output logic        done,
  output logic        hilo_we,
  output logic [63:0] hilo_o
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t      state, state_n;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [63:0] prod_q;
  logic [31:0] rem_q, quo_q;
  logic [4:0]  cnt_q;
  logic        div_q;

  logic        accept, acc_in, acc_q_op, to_mul;
  logic [31:0] abs_a_in, dvsr;
  logic [63:0] prod, prod_acc;

  assign accept = (state == IDLE) && start && !flush;

`ifdef HILO_MADD_EN
  logic [63:0] acc_q;
  assign acc_in   = op[2];
  assign acc_q_op = op_q[2];
  always_ff @(posedge clk) begin
    if (rst)         acc_q <= '0;
    else if (accept) acc_q <= hilo_cur;
  end
  // op_q[1] distinguishes subtract from add within the accumulate group
  assign prod_acc = !acc_q_op ? prod : (op_q[1] ? acc_q - prod : acc_q + prod);
`else
  logic unused_acc;
  assign acc_in     = 1'b0;
  assign acc_q_op   = 1'b0;
  assign unused_acc = ^{op[2], op_q[2], hilo_cur, acc_q_op};
  assign prod_acc   = prod;
`endif

  assign to_mul = !op[1] || acc_in;

  // One 33x33 signed multiplier covers both signed and unsigned forms
  logic signed [32:0] ma, mb;
  logic signed [65:0] mprod;
  logic [1:0]         unused_mprod;
  assign ma           = {!op_q[0] && a_q[31], a_q};
  assign mb           = {!op_q[0] && b_q[31], b_q};
  assign mprod        = ma * mb;
  assign prod         = mprod[63:0];
  assign unused_mprod = mprod[65:64];

  assign abs_a_in = (!op[0] && a[31]) ? (~a + 32'd1) : a;
  assign dvsr     = (!op_q[0] && b_q[31]) ? (~b_q + 32'd1) : b_q;

  // Restoring step; a zero divisor always subtracts, leaving q=all-ones, r=|dividend|
  logic [32:0] r_sh, r_diff;
  logic        r_ge;
  assign r_sh   = {rem_q, quo_q[31]};
  assign r_diff = r_sh - {1'b0, dvsr};
  assign r_ge   = r_sh >= {1'b0, dvsr};

  logic        neg_q, neg_r;
  logic [31:0] quo_fix, rem_fix;
  assign neg_q   = !op_q[0] && (a_q[31] ^ b_q[31]);
  assign neg_r   = !op_q[0] && a_q[31];
  assign quo_fix = neg_q ? (~quo_q + 32'd1) : quo_q;
  assign rem_fix = neg_r ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = to_mul ? MUL : DIV;
      MUL:  state_n = FIN;
      DIV:  if (cnt_q == 5'd31) state_n = FIN;
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_comb begin
    busy    = accept || (state == MUL) || (state == DIV);
    done    = (state == FIN) && !flush;
    hilo_we = done;
    hilo_o  = '0;
    if (done) hilo_o = div_q ? {rem_fix, quo_fix} : prod_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q  <= op;
        a_q   <= a;
        b_q   <= b;
        div_q <= !to_mul;
        cnt_q <= '0;
        rem_q <= '0;
        quo_q <= abs_a_in;
      end else if (state == MUL) begin
        prod_q <= prod_acc;
      end else if (state == DIV) begin
        rem_q <= r_ge ? r_diff[31:0] : r_sh[31:0];
        quo_q <= {quo_q[30:0], r_ge};
        cnt_q <= cnt_q + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: directed ops push expected {value, cycle}; a monitor checks each done.
module tb_hilo_muldiv;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic [63:0] hilo_cur = '0;
  logic        busy, done, hilo_we;
  logic [63:0] hilo_o;

  hilo_muldiv dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op), .a(a), .b(b),
    .hilo_cur(hilo_cur), .busy(busy), .done(done), .hilo_we(hilo_we), .hilo_o(hilo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] v;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int cyc = 0, errors = 0, checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Monitor: compares every done against the scoreboard head, and checks idle outputs stay 0
  always @(negedge clk) begin
    if (!rst) begin
      chk("we_eq_done", {63'd0, hilo_we}, {63'd0, done});
      if (done) begin
        chk("busy_in_fin", {63'd0, busy}, 64'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("hilo_o", hilo_o, e.v);
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        chk("hilo_o_idle", hilo_o, 64'd0);
      end
    end
  end

  // Issue one op in the cycle after the call; hold busy checks until the expected done cycle
  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [63:0] cur, input logic [63:0] ev, input int lat);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y; hilo_cur = cur;
    sb.push_back('{ev, cyc + lat});
    @(negedge clk);
    chk("busy_issue", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0; a = 32'hDEADBEEF; b = 32'h0BADF00D; hilo_cur = 64'hFFFF_0000_FFFF_0000;
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      chk("busy_run", {63'd0, busy}, 64'd1);
    end
    @(negedge clk);
  endtask

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", hilo_o, 64'd0);

    run(3'b000, 32'hFFFFFFFD, 32'd5, 64'd0, 64'hFFFFFFFF_FFFFFFF1, 2);
    run(3'b011, 32'd100, 32'd7, 64'd0, 64'h00000002_0000000E, 33);
    run(3'b010, 32'hFFFFFFF9, 32'd2, 64'd0, 64'hFFFFFFFF_FFFFFFFD, 33);
    run(3'b011, 32'h12345678, 32'd0, 64'd0, 64'h12345678_FFFFFFFF, 33);
    run(3'b010, 32'h80000000, 32'hFFFFFFFF, 64'd0, 64'h00000000_80000000, 33);
    run(3'b010, 32'd7, 32'hFFFFFFFE, 64'd0, 64'h00000001_FFFFFFFD, 33);
    run(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 64'hFFFFFFFE_00000001, 2);
    run(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 64'h00000000_00000001, 2);
`ifdef HILO_MADD_EN
    run(3'b100, 32'd2, 32'd3, 64'h10, 64'h00000000_00000016, 2);
    run(3'b110, 32'd2, 32'd3, 64'h10, 64'h00000000_0000000A, 2);
    run(3'b101, 32'd1, 32'd1, 64'hFFFFFFFF_FFFFFFFF, 64'd0, 2);
`else
    run(3'b100, 32'd2, 32'd3, 64'h10, 64'h00000000_00000006, 2);
    run(3'b110, 32'd2, 32'd3, 64'h10, 64'h00000002_00000000, 33);
    run(3'b101, 32'd1, 32'd1, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 2);
`endif

    // Flush mid-divide: nothing is written, busy drops the next cycle
    @(posedge clk); #1;
    start = 1'b1; op = 3'b011; a = 32'd1000; b = 32'd3; t0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    while (cyc < t0 + 10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("busy_after_flush", {63'd0, busy}, 64'd0);
    end

    // Flush at cycle 10, fresh start at 11 finishes at 44
    @(posedge clk); #1;
    start = 1'b1; op = 3'b011; a = 32'd50; b = 32'd3; t0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    while (cyc < t0 + 10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    sb.push_back('{64'h00000002_0000000E, t0 + 44});
    @(posedge clk); #1 start = 1'b0;
    repeat (36) @(negedge clk);

    // Flush in FIN suppresses done
    @(posedge clk); #1;
    start = 1'b1; op = 3'b000; a = 32'd4; b = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("fin_flush_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1 flush = 1'b0;

    // flush beats start in IDLE
    start = 1'b1; flush = 1'b1; op = 3'b000;
    @(negedge clk);
    chk("flush_beats_start", {63'd0, busy}, 64'd0);
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    repeat (4) @(negedge clk);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle multiply/divide unit that produces the 64-bit HI/LO result for MULT/MULTU/DIV/DIVU (and, optionally, MADD/MSUB) in the CDIM MIPS datapath. It sits in the execute stage, accepts one operation at a time through a start/busy/done handshake, and drives the write port (`we`, `hilo_i`) of the HI/LO register. It is the producer end of that register interface. Multiply takes 2 cycles; divide is a radix-2 restoring divider taking 33 cycles.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline cancel; aborts any operation in progress, no write
- start  in  1  request to begin op; sampled only in IDLE
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
- a  in  32  rs operand (multiplicand / dividend)
- b  in  32  rt operand (multiplier / divisor)
- hilo_cur  in  64  current HI/LO register contents, used for accumulate ops
- busy  out  1  stall request to the pipeline
- done  out  1  one-cycle pulse, result valid
- hilo_we  out  1  write enable to the HI/LO register; equals done
- hilo_o  out  64  {HI, LO} result; HI = product[63:32] / remainder, LO = product[31:0] / quotient

## Operation
- States: IDLE, MUL, DIV, FIN.
- IDLE + start + !flush: latch a, b, op and hilo_cur. Next state is MUL for op[1]=0, else DIV (iteration counter cleared).
- MUL: compute the 64-bit product of the latched operands. Signed when op[0]=0, unsigned when op[0]=1. Register the product, then go to FIN.
- DIV: the signed variant divides magnitudes. Each cycle performs one shift/subtract step, 32 iterations, then FIN.
- Sign correction in FIN:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero produces the natural restoring result with no exception: magnitude quotient 0xFFFFFFFF, remainder = |dividend|, then sign correction. Only DIVU is architecturally checked (LO=0xFFFFFFFF, HI=a).
- 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0.
- FIN: done=hilo_we=1, hilo_o valid. Next state is IDLE.
- flush in any state: next state is IDLE. If flush is high in FIN, done and hilo_we are forced to 0 that cycle. flush beats start in the same cycle.
- start outside IDLE is ignored.
- Outputs are held at 0 whenever done=0.

## Timing
- Reset: state=IDLE, busy=0, done=0, hilo_we=0, hilo_o=0, counter=0, all internal registers 0.
- start in cycle 0 gives:
  - MUL: done in cycle 2.
  - DIV: done in cycle 33.
- busy = (start & IDLE & !flush) | MUL | DIV. busy is low in FIN so the stalled instruction advances in the same cycle the result is written.
- hilo_o and done are registered/state-decoded and are not combinational from a/b.
- A new start is accepted in the cycle after FIN (back-to-back gap of 0 idle cycles beyond FIN).
- hilo_cur is sampled at the start edge. Later writes to HI/LO do not affect an in-flight accumulate.

## Configuration
- `HILO_MADD_EN` defined: op[2]=1 selects accumulate.
  - MADD/MADDU: hilo_o = hilo_cur + product.
  - MSUB/MSUBU: hilo_o = hilo_cur − product.
  - 64-bit modular arithmetic in both cases; latency unchanged.
- Undefined: op[2] is ignored, so ops 100–111 behave as 000/001/010/011. The hilo_cur capture register and the adder are not built.

## Test plan
- MULT a=0xFFFFFFFD, b=5, start cycle 0 → cycle 2: done=1, hilo_we=1, hilo_o=0xFFFFFFFF_FFFFFFF1. busy=1 in cycles 0–1, 0 in cycle 2.
- DIVU a=100, b=7 → cycle 33: hilo_o=0x00000002_0000000E. busy high in cycles 0–32.
- DIV a=0xFFFFFFF9 (−7), b=2 → hilo_o=0xFFFFFFFF_FFFFFFFD (HI=−1, LO=−3).
- DIVU a=0x12345678, b=0 → hilo_o=0x12345678_FFFFFFFF, no hang.
- DIVU started cycle 0, flush in cycle 10 → no done or hilo_we ever, busy=0 from cycle 11. A start in cycle 11 gets its result in cycle 44.
- MADD hilo_cur=0x00000000_00000010, a=2, b=3:
  - with `HILO_MADD_EN` → hilo_o=0x00000000_00000016.
  - without → 0x00000000_00000006.
